mem_copy_master: RTL and testbench
==================================

Name: mem_copy_master

Overview:
- Bus initiator on the CPU-side memory-map interface: drives addr/we/wd and samples rd.
- Copies a block of words from any readable region (image ROM or data RAM) into data RAM.
- Optionally waits for the board switch before starting.
- Sits beside the CPU on the memory controller port, behind a bus mux that is outside this block; used for frame/image preload without CPU loops.

Parameters:
- ROM_LAST, 152099, last image ROM word address.
- RAM_FIRST, 152100, first data RAM word address.
- RAM_LAST, 305735, last data RAM word address.
- SW_ADDR, 305736, switch status address; bit0 = switch.
- LEN_W, 18, width of the length/counter.
- WAIT_SWITCH, 1, 1 = poll SW_ADDR until bit0 = 1 before copying.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  1-cycle request; sampled only in IDLE.
- abort  in  1  terminate the transfer at the next state boundary.
- src_addr  in  32  first source word address.
- dst_addr  in  32  first destination word address.
- len  in  LEN_W  word count.
- bus_addr  out  32  address to the memory controller.
- bus_we  out  1  write enable.
- bus_wd  out  32  write data.
- bus_rd  in  32  combinational read data, valid in the same cycle as bus_addr.
- busy  out  1  high in POLL/READ/WRITE.
- done  out  1  1-cycle pulse at the end of any transfer, including error, abort and zero length.
- err  out  1  sticky range-error flag; cleared by the next accepted start.

Behaviour:
- Reset (async, on rst_n low), including mid-transfer:
  - state = IDLE; bus_addr, bus_wd, data_q, src_q, dst_q, cnt = 0.
  - bus_we, busy, done, err = 0. bus_we drops immediately.
- States: IDLE, POLL, READ, WRITE, FIN.
- IDLE: bus outputs 0. On start:
  - latch src_q, dst_q, len_q; cnt = 0; err = 0.
  - Range check, on src+len-1 and dst+len-1 computed in 33 bits to catch wrap:
    - len == 0 -> FIN, no bus activity, err = 0.
    - src+len-1 > RAM_LAST, or dst < RAM_FIRST, or dst+len-1 > RAM_LAST -> err = 1, go to FIN, no bus cycle issued.
    - otherwise go to POLL if WAIT_SWITCH, else READ.
- POLL: bus_addr = SW_ADDR, bus_we = 0. bus_rd[0] = 1 -> READ next cycle; else stay.
- READ: bus_addr = src_q+cnt, bus_we = 0; data_q <= bus_rd at the clock edge; go to WRITE.
- WRITE: bus_addr = dst_q+cnt, bus_we = 1, bus_wd = data_q; cnt++.
  - If cnt == len_q-1 -> FIN, else READ.
- FIN: done = 1 for exactly one cycle; bus outputs 0; go to IDLE. busy = 0 in FIN.
- Throughput: 2 cycles/word.
- Latency, WAIT_SWITCH = 0: start at cycle 0, first READ at cycle 1, last WRITE at cycle 2·len, done at cycle 2·len+1.
- abort:
  - In POLL or READ -> FIN; no further write.
  - In WRITE -> the current write completes, then FIN.
  - err is unchanged by abort.
- start while not IDLE: ignored. start and abort together in IDLE: start wins; abort is ignored in IDLE.
- Overlapping RAM src/dst: strict ascending word order; the result is exactly that of a sequential forward copy.
- Reads from SW_ADDR or unmapped addresses are never issued during a copy; the range check guarantees this.
- All bus outputs are registered; no combinational path from bus_rd to any output.

Decomposition:
- mem_map_pkg holds:
  - address-map constants ROM_LAST, RAM_FIRST, RAM_LAST, SW_ADDR;
  - the state enum typedef copy_state_t.
- Module parameters default from the package.
- One sub-module: copy_range_check, a combinational validity check (src, dst, len -> ok/err) with 33-bit arithmetic, reusable by a later CPU-side DMA register block.

Test Plan:
- WAIT_SWITCH = 0, src = 0, dst = 152100, len = 4, ROM words 0..3 = A,B,C,D -> RAM 152100..152103 = A..D; done at cycle 9; busy cycles 1–8; err = 0.
- WAIT_SWITCH = 1, switch = 0 for 10 cycles, then 1 -> bus_addr = 305736 with we = 0 throughout the wait; the first READ occurs the cycle after the switch is seen high; copy completes correctly.
- Range errors, each -> err = 1, done pulse 1 cycle after start, bus_we never asserted:
  - dst = 100, len = 1;
  - src = 305735, len = 2;
  - dst = 305735, len = 2.
- len = 0 -> done 1 cycle after start, err = 0, no bus cycle; the next start clears a previous err.
- Overlap: RAM 152100..152103 = 1,2,3,4; src = 152100, dst = 152101, len = 3 -> RAM = 1,1,1,1 (forward-copy semantics).
- Abort:
  - asserted in the WRITE of word 2 of len = 8 -> exactly 3 words written, done pulses, err = 0.
  - rst_n low mid-WRITE -> bus_we = 0 immediately, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Address map and copy-engine state encoding shared by the
// memory-copy master and future DMA-side blocks.
package mem_map_pkg;

  localparam logic [31:0] ROM_LAST  = 32'd152099;
  localparam logic [31:0] RAM_FIRST = 32'd152100;
  localparam logic [31:0] RAM_LAST  = 32'd305735;
  localparam logic [31:0] SW_ADDR   = 32'd305736;
  localparam int          LEN_W     = 18;

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    READ,
    WRITE,
    FIN
  } copy_state_t;

endpackage

// File: rtl/copy_range_check.sv
// Combinational validity check of a block copy request.
// Ends are computed in 33 bits so address wrap is caught.
module copy_range_check #(
  parameter logic [31:0] ROM_LAST  = mem_map_pkg::ROM_LAST,
  parameter logic [31:0] RAM_FIRST = mem_map_pkg::RAM_FIRST,
  parameter logic [31:0] RAM_LAST  = mem_map_pkg::RAM_LAST,
  parameter int          LEN_W     = mem_map_pkg::LEN_W
) (
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             ok,
  output logic             err
);

  logic [32:0] src_end;
  logic [32:0] dst_end;
  logic        zero;
  logic        hole;
  logic        src_bad;
  logic        dst_bad;

  assign zero    = (len == '0);
  assign src_end = {1'b0, src} + 33'(len) - 33'd1;
  assign dst_end = {1'b0, dst} + 33'(len) - 33'd1;

  // Only matters if the map ever gets a gap between ROM and RAM.
  assign hole = ((33'(ROM_LAST) + 33'd1) < 33'(RAM_FIRST))
             && (src < RAM_FIRST)
             && (src_end > 33'(ROM_LAST));

  assign src_bad = (src_end > 33'(RAM_LAST)) || hole;
  assign dst_bad = (dst < RAM_FIRST) || (dst_end > 33'(RAM_LAST));

  assign err = !zero && (src_bad || dst_bad);
  assign ok  = !zero && !err;

endmodule

// File: rtl/mem_copy_master.sv
// Bus initiator copying a word block into data RAM,
// two cycles per word, optionally gated by the board switch.
module mem_copy_master
  import mem_map_pkg::*;
#(
  parameter logic [31:0] ROM_LAST    = mem_map_pkg::ROM_LAST,
  parameter logic [31:0] RAM_FIRST   = mem_map_pkg::RAM_FIRST,
  parameter logic [31:0] RAM_LAST    = mem_map_pkg::RAM_LAST,
  parameter logic [31:0] SW_ADDR     = mem_map_pkg::SW_ADDR,
  parameter int          LEN_W       = mem_map_pkg::LEN_W,
  parameter bit          WAIT_SWITCH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic [31:0]      bus_addr,
  output logic             bus_we,
  output logic [31:0]      bus_wd,
  input  logic [31:0]      bus_rd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  copy_state_t      state, nxt;
  logic [31:0]      src_q, dst_q, src_n, dst_n;
  logic [31:0]      data_q, addr_n, off;
  logic [LEN_W-1:0] len_q, len_n, cnt, cnt_n;
  logic             we_n, busy_n, done_n, err_n;
  logic             rc_ok, rc_err;

  copy_range_check #(
    .ROM_LAST (ROM_LAST),
    .RAM_FIRST(RAM_FIRST),
    .RAM_LAST (RAM_LAST),
    .LEN_W    (LEN_W)
  ) u_rc (
    .src(src_addr),
    .dst(dst_addr),
    .len(len),
    .ok (rc_ok),
    .err(rc_err)
  );

  always_comb begin
    nxt   = state;
    src_n = src_q;
    dst_n = dst_q;
    len_n = len_q;
    cnt_n = cnt;
    err_n = err;
    unique case (state)
      IDLE: begin
        if (start) begin
          src_n = src_addr;
          dst_n = dst_addr;
          len_n = len;
          cnt_n = '0;
          err_n = rc_err;
          if (!rc_ok)           nxt = FIN;
          else if (WAIT_SWITCH) nxt = POLL;
          else                  nxt = READ;
        end
      end
      POLL: begin
        if (abort)          nxt = FIN;
        else if (bus_rd[0]) nxt = READ;
      end
      READ: nxt = abort ? FIN : WRITE;
      WRITE: begin
        cnt_n = cnt + 1'b1;
        nxt   = (abort || cnt_n == len_q) ? FIN : READ;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Bus outputs are computed for the next state and registered.
  always_comb begin
    off    = 32'(cnt_n);
    addr_n = '0;
    we_n   = 1'b0;
    if (nxt == POLL) addr_n = SW_ADDR;
    if (nxt == READ) addr_n = src_n + off;
    if (nxt == WRITE) begin
      addr_n = dst_n + off;
      we_n   = 1'b1;
    end
    busy_n = (nxt == POLL) || (nxt == READ) || (nxt == WRITE);
    done_n = (nxt == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      cnt      <= '0;
      data_q   <= '0;
      bus_addr <= '0;
      bus_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= nxt;
      src_q    <= src_n;
      dst_q    <= dst_n;
      len_q    <= len_n;
      cnt      <= cnt_n;
      if (state == READ) data_q <= bus_rd;
      bus_addr <= addr_n;
      bus_we   <= we_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  assign bus_wd = bus_we ? data_q : '0;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: per-cycle trace model plus
// hand-computed checks on latency, memory contents and errors.
module tb_mem_copy_master;
  import mem_map_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    int          wsrc;
    logic        busy;
    logic        done;
    logic        err;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        abort = 1'b0;
  logic        sw = 1'b0;
  logic [31:0] src = '0, dst = '0;
  logic [17:0] len = '0;
  logic [31:0] addr0, wd0, rd0, addr1, wd1, rd1;
  logic        we0, busy0, done0, err0;
  logic        we1, busy1, done1, err1;

  bit [31:0] mem  [0:305735];
  bit [31:0] rmem [0:305735];
  rec_t q0[$];
  rec_t q1[$];
  logic last_err [2];
  int errors = 0;
  int checks = 0;

  mem_copy_master #(.WAIT_SWITCH(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .src_addr(src), .dst_addr(dst), .len(len),
    .bus_addr(addr0), .bus_we(we0), .bus_wd(wd0), .bus_rd(rd0),
    .busy(busy0), .done(done0), .err(err0)
  );

  mem_copy_master #(.WAIT_SWITCH(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .src_addr(src), .dst_addr(dst), .len(len),
    .bus_addr(addr1), .bus_we(we1), .bus_wd(wd1), .bus_rd(rd1),
    .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == SW_ADDR) return {31'b0, sw};
    if (a <= RAM_LAST) return mem[a];
    return '0;
  endfunction

  assign rd0 = rd_of(addr0);
  assign rd1 = rd_of(addr1);

  always @(posedge clk) begin
    if (we0 && addr0 >= RAM_FIRST && addr0 <= RAM_LAST) mem[addr0] = wd0;
    if (we1 && addr1 >= RAM_FIRST && addr1 <= RAM_LAST) mem[addr1] = wd1;
  end

  task automatic push(input int k, input rec_t r);
    if (k == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Expected cycle trace of one request, starting at the start cycle.
  task automatic model(input int k, input longint s, input longint d,
                       input longint n, input int poll, input int stop);
    rec_t r;
    logic e;
    longint w;
    e = (n != 0) && ((s + n - 1 > RAM_LAST) || (d < RAM_FIRST)
                     || (d + n - 1 > RAM_LAST));
    r = '{addr: 0, we: 0, wsrc: 0, busy: 0, done: 0, err: last_err[k]};
    push(k, r);
    if (n != 0 && !e) begin
      for (int p = 0; p < poll; p++) begin
        r = '{addr: SW_ADDR, we: 0, wsrc: 0, busy: 1, done: 0, err: 0};
        push(k, r);
      end
      w = (stop >= 0) ? stop : n;
      for (longint i = 0; i < w; i++) begin
        r = '{addr: 32'(s + i), we: 0, wsrc: 0, busy: 1, done: 0, err: 0};
        push(k, r);
        r = '{addr: 32'(d + i), we: 1, wsrc: int'(s + i), busy: 1,
              done: 0, err: 0};
        push(k, r);
      end
    end
    r = '{addr: 0, we: 0, wsrc: 0, busy: 0, done: 1, err: e};
    push(k, r);
  endtask

  task automatic check_dut(input int k);
    rec_t r;
    logic [31:0] a, wd, xwd;
    logic we, b, dn, e;
    r = '{addr: 0, we: 0, wsrc: 0, busy: 0, done: 0, err: last_err[k]};
    if (k == 0) begin
      a = addr0; we = we0; wd = wd0; b = busy0; dn = done0; e = err0;
      if (q0.size() > 0) r = q0.pop_front();
    end else begin
      a = addr1; we = we1; wd = wd1; b = busy1; dn = done1; e = err1;
      if (q1.size() > 0) r = q1.pop_front();
    end
    xwd = r.we ? rmem[r.wsrc] : '0;
    checks++;
    if ({a, we, wd, b, dn, e} !== {r.addr, r.we, xwd, r.busy, r.done, r.err}) begin
      errors++;
      $display("FAIL trace dut%0d t=%0t addr=%0d/%0d we=%b/%b wd=%h/%h busy=%b/%b done=%b/%b err=%b/%b",
               k, $time, a, r.addr, we, r.we, wd, xwd, b, r.busy, dn, r.done, e, r.err);
    end
    if (r.we) rmem[r.addr] = xwd;
    last_err[k] = r.err;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_dut(0);
      check_dut(1);
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int a, input logic [31:0] v);
    mem[a]  = v;
    rmem[a] = v;
  endtask

  task automatic go(input int k, input logic [31:0] s, input logic [31:0] d,
                    input int n, input int poll, input int stop);
    src = s;
    dst = d;
    len = 18'(n);
    model(k, s, d, n, poll, stop);
    if (k == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    tick;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int c;
    c = 0;
    while (((k == 0) ? q0.size() : q1.size()) > 0 && c < 500) begin
      tick;
      c++;
    end
    chk("drain_timeout", (c < 500) ? 1 : 0, 1);
    tick;
  endtask

  initial begin
    int c, nb;
    logic ok;
    last_err[0] = 1'b0;
    last_err[1] = 1'b0;
    for (int i = 0; i < 8; i++) setw(i, 32'hA0A0_0000 + 32'(i) + 1);
    #1;
    chk("reset_outs", {addr0, we0, wd0, busy0, done0, err0}, 0);
    chk("reset_outs1", {addr1, we1, wd1, busy1, done1, err1}, 0);
    #21 rst_n = 1'b1;
    tick;

    // Basic copy, WAIT_SWITCH = 0.
    go(0, 0, 152100, 4, 0, -1);
    c = 1;
    nb = 0;
    while (c < 50) begin
      if (busy0) nb++;
      if (done0) break;
      tick;
      c++;
    end
    chk("done_cycle", c, 9);
    chk("busy_cycles", nb, 8);
    chk("err_basic", err0, 0);
    wait_idle(0);
    chk("ram0", mem[152100], 32'hA0A0_0001);
    chk("ram3", mem[152103], 32'hA0A0_0004);

    // Switch gating on the WAIT_SWITCH = 1 instance.
    sw = 1'b0;
    go(1, 0, 152200, 2, 11, -1);
    ok = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (addr1 !== SW_ADDR || we1 !== 1'b0) ok = 1'b0;
      tick;
    end
    chk("poll_bus", ok, 1);
    sw = 1'b1;
    tick;
    chk("first_read", addr1, 0);
    wait_idle(1);
    sw = 1'b0;
    chk("sw_ram1", mem[152201], 32'hA0A0_0002);

    // Range errors: done one cycle after start, no bus cycle.
    go(0, 0, 100, 1, 0, -1);
    chk("rng_dst_lo", {done0, err0}, 3);
    wait_idle(0);
    go(0, 305735, 152100, 2, 0, -1);
    chk("rng_src_hi", {done0, err0}, 3);
    wait_idle(0);
    go(0, 0, 305735, 2, 0, -1);
    chk("rng_dst_hi", {done0, err0}, 3);
    wait_idle(0);

    // Zero length clears the sticky error.
    go(0, 0, 152100, 0, 0, -1);
    chk("len0", {done0, err0, busy0}, 4);
    wait_idle(0);

    // Overlapping forward copy.
    for (int i = 0; i < 4; i++) setw(152100 + i, 32'(i + 1));
    go(0, 152100, 152101, 3, 0, -1);
    wait_idle(0);
    for (int i = 0; i < 4; i++) chk("overlap", mem[152100 + i], 1);

    // Abort in the WRITE of word 2 of 8.
    go(0, 0, 152300, 8, 0, 3);
    for (int i = 0; i < 5; i++) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    wait_idle(0);
    chk("abort_w2", mem[152302], 32'hA0A0_0003);
    chk("abort_w3", mem[152303], 0);
    chk("abort_err", err0, 0);

    // Reset in the middle of a WRITE.
    go(0, 0, 152400, 4, 0, -1);
    for (int i = 0; i < 5; i++) tick;
    chk("pre_rst_we", we0, 1);
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    last_err[0] = 1'b0;
    last_err[1] = 1'b0;
    #1;
    chk("rst_outs", {addr0, we0, wd0, busy0, done0, err0}, 0);
    chk("rst_state", (dut0.state == IDLE) ? 1 : 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick;
    tick;
    chk("rst_w1", mem[152401], 32'hA0A0_0002);
    chk("rst_w2", mem[152402], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
